// File: rtl/ex_alu_unit.sv
// Single-cycle integer/branch execute unit with a 2-entry result buffer draining to the CDB.
// Latency in_valid->cdb_req 1 cycle (MUL 3 cycles when EX_ALU_MUL_EN is defined); alu_ready drops when the buffer is full or a MUL is in flight.
// Optional multiplier: define EX_ALU_MUL_EN; otherwise op 30 is treated as an unknown op.
module ex_alu_unit #(
    parameter int ROB_W     = 5,
    parameter int OP_W      = 6,
    parameter int BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  in_op,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_pc,
    input  logic [ROB_W-1:0] in_rd_tag,
    output logic             alu_ready,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic             alu_broadcast,
    output logic [31:0]      alu_cbd_value,
    output logic [ROB_W-1:0] alu_update_rename,
    output logic             br_valid,
    output logic             br_taken,
    output logic [31:0]      br_target
);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(9);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(15);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(21);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(22);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(23);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(24);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(25);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(26);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(27);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(28);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(29);
    localparam logic [1:0]      FULL     = 2'(BUF_DEPTH);

    typedef struct packed {
        logic [31:0]      value;
        logic [ROB_W-1:0] tag;
        logic             is_br;
        logic             taken;
        logic [31:0]      target;
    } res_t;

    res_t        buf_q [BUF_DEPTH];
    res_t        head_e;
    res_t        alu_res;
    res_t        wr_dat;
    logic        head, tail;
    logic [1:0]  count;
    logic [31:0] opb;
    logic [4:0]  shamt;
    logic        take;
    logic        accept, drain, wr_en, mul_busy;

    // Immediate-form ALU ops (ADDI..SRAI) take the immediate as operand 2.
    always_comb begin
        opb     = (in_op >= OP_ADDI && in_op <= OP_SRAI) ? in_imm : in_rs2;
        shamt   = opb[4:0];
        take    = 1'b0;
        alu_res = '0;
        alu_res.tag = in_rd_tag;
        case (in_op)
            OP_ADD, OP_ADDI:   alu_res.value = in_rs1 + opb;
            OP_SUB:            alu_res.value = in_rs1 - opb;
            OP_SLL, OP_SLLI:   alu_res.value = in_rs1 << shamt;
            OP_SLT, OP_SLTI:   alu_res.value = {31'b0, $signed(in_rs1) < $signed(opb)};
            OP_SLTU, OP_SLTIU: alu_res.value = {31'b0, in_rs1 < opb};
            OP_XOR, OP_XORI:   alu_res.value = in_rs1 ^ opb;
            OP_SRL, OP_SRLI:   alu_res.value = in_rs1 >> shamt;
            OP_SRA, OP_SRAI:   alu_res.value = 32'($signed(in_rs1) >>> shamt);
            OP_OR, OP_ORI:     alu_res.value = in_rs1 | opb;
            OP_AND, OP_ANDI:   alu_res.value = in_rs1 & opb;
            OP_LUI:            alu_res.value = in_imm;
            OP_AUIPC:          alu_res.value = in_pc + in_imm;
            OP_JAL, OP_JALR:   alu_res.value = in_pc + 32'd4;
            OP_BEQ:            take = (in_rs1 == in_rs2);
            OP_BNE:            take = (in_rs1 != in_rs2);
            OP_BLT:            take = ($signed(in_rs1) < $signed(in_rs2));
            OP_BGE:            take = ($signed(in_rs1) >= $signed(in_rs2));
            OP_BLTU:           take = (in_rs1 < in_rs2);
            OP_BGEU:           take = (in_rs1 >= in_rs2);
            default:           ;
        endcase
        if (in_op == OP_JAL || in_op == OP_JALR) begin
            alu_res.is_br  = 1'b1;
            alu_res.taken  = 1'b1;
            alu_res.target = (in_op == OP_JAL) ? in_pc + in_imm
                                               : (in_rs1 + in_imm) & ~32'd1;
        end
        if (in_op >= OP_BEQ && in_op <= OP_BGEU) begin
            alu_res.is_br  = 1'b1;
            alu_res.taken  = take;
            alu_res.target = take ? in_pc + in_imm : in_pc + 32'd4;
        end
    end

    assign alu_ready = (count < FULL) && !mul_busy;
    assign accept    = rdy && !rst && !flush && in_valid && alu_ready;

`ifdef EX_ALU_MUL_EN
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(30);
    typedef enum logic [1:0] {M_IDLE, M_1, M_2} mul_st_t;

    mul_st_t          mul_st, mul_st_nxt;
    logic [31:0]      mul_a, mul_b, mul_p;
    logic [ROB_W-1:0] mul_tag;
    logic             mul_start, mul_wr;

    assign mul_start = accept && (in_op == OP_MUL);

    always_ff @(posedge clk) begin
        if (rst || flush)
            mul_st <= M_IDLE;
        else if (rdy)
            mul_st <= mul_st_nxt;
    end

    always_comb begin
        mul_st_nxt = mul_st;
        case (mul_st)
            M_IDLE:  if (mul_start) mul_st_nxt = M_1;
            M_1:     mul_st_nxt = M_2;
            M_2:     mul_st_nxt = M_IDLE;
            default: mul_st_nxt = M_IDLE;
        endcase
    end

    always_comb begin
        mul_busy = (mul_st != M_IDLE);
        mul_wr   = (mul_st == M_2) && rdy && !flush && !rst;
    end

    always_ff @(posedge clk) begin
        if (mul_start) begin
            mul_a   <= in_rs1;
            mul_b   <= in_rs2;
            mul_tag <= in_rd_tag;
        end
        if (mul_st == M_1 && rdy)
            mul_p <= mul_a * mul_b;
    end

    // alu_ready is low while the FSM is busy, so a MUL write never collides with an ALU write.
    assign wr_en  = (accept && !mul_start) || mul_wr;
    assign wr_dat = mul_wr ? res_t'{value: mul_p, tag: mul_tag, is_br: 1'b0,
                                    taken: 1'b0, target: 32'd0} : alu_res;
`else
    assign mul_busy = 1'b0;
    assign wr_en    = accept;
    assign wr_dat   = alu_res;
`endif

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (rdy) begin
            if (wr_en) begin
                buf_q[tail] <= wr_dat;
                tail        <= ~tail;
            end
            if (drain)
                head <= ~head;
            count <= count + {1'b0, wr_en} - {1'b0, drain};
        end
    end

    assign head_e            = buf_q[head];
    assign cdb_req           = (count != 2'd0);
    assign alu_broadcast     = cdb_req && cdb_grant && rdy && !flush && !rst;
    assign drain             = alu_broadcast;
    assign alu_cbd_value     = head_e.value;
    assign alu_update_rename = head_e.tag;
    assign br_valid          = cdb_req && head_e.is_br;
    assign br_taken          = head_e.taken;
    assign br_target         = head_e.target;
endmodule

// File: tb/tb_ex_alu_unit.sv
// Randomized and directed bench for ex_alu_unit against a queue-based reference model.
module tb_ex_alu_unit;
    logic        clk, rst, rdy, flush, in_valid, cdb_grant;
    logic [5:0]  in_op;
    logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
    logic [4:0]  in_rd_tag;
    logic        alu_ready, cdb_req, alu_broadcast, br_valid, br_taken;
    logic [31:0] alu_cbd_value, br_target;
    logic [4:0]  alu_update_rename;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] value;
        logic [4:0]  tag;
        logic        br;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t q[$];

    ex_alu_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_pc(in_pc), .in_rd_tag(in_rd_tag),
        .alu_ready(alu_ready), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
        .alu_broadcast(alu_broadcast), .alu_cbd_value(alu_cbd_value),
        .alu_update_rename(alu_update_rename), .br_valid(br_valid),
        .br_taken(br_taken), .br_target(br_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_op(input int op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] imm, input logic [31:0] pc,
                                      input logic [4:0] tag);
        exp_t        r;
        logic [31:0] o2;
        logic        tk;
        int          sh;
        r = '{value: 32'd0, tag: tag, br: 1'b0, taken: 1'b0, target: 32'd0};
        o2 = (op >= 11 && op <= 19) ? imm : b;
        sh = int'(o2[4:0]);
        tk = 1'b0;
        case (op)
            1, 11:  r.value = a + o2;
            2:      r.value = a - o2;
            3, 17:  r.value = a << sh;
            4, 12:  r.value = ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0;
            5, 13:  r.value = (a < o2) ? 32'd1 : 32'd0;
            6, 14:  r.value = a ^ o2;
            7, 18:  r.value = a >> sh;
            8, 19:  for (int i = 0; i < 32; i++) r.value[i] = (i + sh < 32) ? a[i + sh] : a[31];
            9, 15:  r.value = a | o2;
            10, 16: r.value = a & o2;
            20:     r.value = imm;
            21:     r.value = pc + imm;
            22, 23: begin
                r.value  = pc + 32'd4;
                r.br     = 1'b1;
                r.taken  = 1'b1;
                r.target = (op == 22) ? pc + imm : (a + imm) & 32'hFFFF_FFFE;
            end
            24: tk = (a == b);
            25: tk = (a != b);
            26: tk = ($signed(a) < $signed(b));
            27: tk = !($signed(a) < $signed(b));
            28: tk = (a < b);
            29: tk = !(a < b);
            default: ;
        endcase
        if (op >= 24 && op <= 29) begin
            r.br     = 1'b1;
            r.taken  = tk;
            r.target = pc + (tk ? imm : 32'd4);
        end
        return r;
    endfunction

    task automatic issue(input bit v, input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] tag);
        in_valid  = v;
        in_op     = 6'(op);
        in_rs1    = a;
        in_rs2    = b;
        in_imm    = imm;
        in_pc     = pc;
        in_rd_tag = tag;
    endtask

    task automatic idle();
        issue(1'b0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    endtask

    // Compare outputs for the current cycle, then advance the model across the clock edge.
    task automatic step();
        exp_t h;
        bit   bc;
        #2;
        chk("cdb_req", 32'(cdb_req), 32'(q.size() > 0));
        chk("alu_ready", 32'(alu_ready), 32'(q.size() < 2));
        bc = rdy && !flush && cdb_grant && (q.size() > 0);
        chk("broadcast", 32'(alu_broadcast), 32'(bc));
        if (q.size() > 0) begin
            h = q[0];
            chk("value", alu_cbd_value, h.value);
            chk("tag", 32'(alu_update_rename), 32'(h.tag));
            chk("br_valid", 32'(br_valid), 32'(h.br));
            if (h.br) begin
                chk("br_taken", 32'(br_taken), 32'(h.taken));
                chk("br_target", br_target, h.target);
            end
        end else begin
            chk("br_valid_empty", 32'(br_valid), 32'd0);
        end
        if (flush) begin
            q.delete();
        end else if (rdy) begin
            bit acc;
            acc = in_valid && (q.size() < 2);
            if (bc) void'(q.pop_front());
            if (acc) q.push_back(model_op(int'(in_op), in_rs1, in_rs2, in_imm, in_pc, in_rd_tag));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; rdy = 1'b1; flush = 1'b0; cdb_grant = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cdb_req", 32'(cdb_req), 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_broadcast", 32'(alu_broadcast), 32'd0);
        chk("rst_br_valid", 32'(br_valid), 32'd0);
        rst = 1'b0;

        // ADD 5+7 -> tag 3
        issue(1'b1, 1, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3); step();
        idle(); #1;
        chk("add_bcast", 32'(alu_broadcast), 32'd1);
        chk("add_value", alu_cbd_value, 32'd12);
        chk("add_tag", 32'(alu_update_rename), 32'd3);
        chk("add_br_valid", 32'(br_valid), 32'd0);
        step();

        // BLT then BLTU with the same operands
        issue(1'b1, 26, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd4); step();
        issue(1'b1, 28, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd5); #1;
        chk("blt_br_valid", 32'(br_valid), 32'd1);
        chk("blt_taken", 32'(br_taken), 32'd1);
        chk("blt_target", br_target, 32'h120);
        step();
        idle(); #1;
        chk("bltu_br_valid", 32'(br_valid), 32'd1);
        chk("bltu_taken", 32'(br_taken), 32'd0);
        chk("bltu_target", br_target, 32'h104);
        step();

        // JALR
        issue(1'b1, 23, 32'h1003, 32'd0, 32'd4, 32'h40, 5'd6); step();
        idle(); #1;
        chk("jalr_value", alu_cbd_value, 32'h44);
        chk("jalr_taken", 32'(br_taken), 32'd1);
        chk("jalr_target", br_target, 32'h1006);
        step();

        // Fill the buffer without grant, then drain in order
        cdb_grant = 1'b0;
        issue(1'b1, 1, 32'd1, 32'd1, 32'd0, 32'd0, 5'd7); step();
        issue(1'b1, 1, 32'd2, 32'd2, 32'd0, 32'd0, 5'd8); step();
        idle(); #1;
        chk("full_alu_ready", 32'(alu_ready), 32'd0);
        step();
        cdb_grant = 1'b1; #1;
        chk("drain1_tag", 32'(alu_update_rename), 32'd7);
        chk("drain1_value", alu_cbd_value, 32'd2);
        step(); #1;
        chk("drain2_tag", 32'(alu_update_rename), 32'd8);
        chk("drain2_value", alu_cbd_value, 32'd4);
        step(); #1;
        chk("drained_ready", 32'(alu_ready), 32'd1);
        step();

        // Flush with a full buffer and an input in the same cycle
        cdb_grant = 1'b0;
        issue(1'b1, 1, 32'd3, 32'd3, 32'd0, 32'd0, 5'd9); step();
        issue(1'b1, 1, 32'd4, 32'd4, 32'd0, 32'd0, 5'd10); step();
        issue(1'b1, 1, 32'd5, 32'd5, 32'd0, 32'd0, 5'd11); flush = 1'b1; step();
        flush = 1'b0; idle(); cdb_grant = 1'b1; #1;
        chk("flush_cdb_req", 32'(cdb_req), 32'd0);
        chk("flush_alu_ready", 32'(alu_ready), 32'd1);
        chk("flush_broadcast", 32'(alu_broadcast), 32'd0);
        step();

        // Random traffic, including stalls, flushes and dropped over-issue
        repeat (3000) begin
            int          op;
            logic [31:0] a;
            op = int'($urandom_range(0, 31));
`ifdef EX_ALU_MUL_EN
            if (op == 30) op = 1;
`endif
            a = $urandom;
            rdy       = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            cdb_grant = ($urandom_range(0, 9) < 6);
            issue(1'($urandom_range(0, 1)), op, a,
                  ($urandom_range(0, 3) == 0) ? a : $urandom,
                  $urandom, $urandom & 32'hFFFF_FFFC, 5'($urandom));
            step();
        end

        rdy = 1'b1; flush = 1'b1; idle(); step();
        flush = 1'b0;

`ifdef EX_ALU_MUL_EN
        // MUL: result appears three cycles after accept
        cdb_grant = 1'b1;
        issue(1'b1, 30, 32'h10000, 32'h10001, 32'd0, 32'd0, 5'd12);
        @(posedge clk); #1;
        idle(); #1;
        chk("mul_c1_ready", 32'(alu_ready), 32'd0);
        chk("mul_c1_req", 32'(cdb_req), 32'd0);
        @(posedge clk); #2;
        chk("mul_c2_ready", 32'(alu_ready), 32'd0);
        chk("mul_c2_req", 32'(cdb_req), 32'd0);
        @(posedge clk); #2;
        chk("mul_bcast", 32'(alu_broadcast), 32'd1);
        chk("mul_value", alu_cbd_value, 32'h0001_0000);
        chk("mul_tag", 32'(alu_update_rename), 32'd12);
        @(posedge clk); #2;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
